// File: rtl/mode_sequencer_pkg.sv
// Shared state encoding, idle command code and index-width helper for mode_sequencer.
package mode_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ANNOUNCE = 3'd1,
    ST_WORK     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RETURN   = 3'd4
  } state_e;

  localparam int CMD_IDLE = 0;

  function automatic int idx_w(input int num_req);
    return $clog2(num_req + 1);
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Command-sender and picture-sender handshake bundle driven by mode_sequencer.
interface mode_sequencer_if #(
  parameter int CMD_W = 2,
  parameter int IDX_W = 2
) ();
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_code;
  logic             cmd_done;
  logic             pic_valid;
  logic [IDX_W-1:0] pic_mode;
  logic             pic_done;

  modport master (
    output cmd_valid, cmd_code, pic_valid, pic_mode,
    input  cmd_done, pic_done
  );

  modport slave (
    input  cmd_valid, cmd_code, pic_valid, pic_mode,
    output cmd_done, pic_done
  );
endinterface

// File: rtl/mode_sequencer_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse (one pulse per low-to-high level change).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic meta_r;
  logic sync_r;
  logic sync_d_r;
  logic pulse_r;

  // Synchronizer chain and edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      sync_d_r <= 1'b0;
      pulse_r  <= 1'b0;
    end else begin
      meta_r   <= din;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
      pulse_r  <= sync_r & ~sync_d_r;
    end
  end

  assign pulse = pulse_r;
endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: grants one request channel at a time and walks it through announce, transfer, optional hold, idle announce.
// Optional handshake watchdog is compiled in when MODE_SEQ_TIMEOUT_EN is defined.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int                 NUM_REQ        = 3,
  parameter int                 CMD_W          = 2,
  parameter logic [NUM_REQ-1:0] HOLD_MASK      = 3'b100,
  parameter int                 TIMEOUT_CYCLES = 50000000
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               finish_i,
  mode_sequencer_if.master   bus,
  output logic               busy,
  output logic               req_drop,
  output logic               err,
  output logic [2:0]         status
);
  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req_edge_s;
  logic               fin_edge_s;
  state_e             state_r;
  state_e             state_nxt_s;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   grant_nxt_s;
  logic [IDX_W-1:0]   sel_s;
  logic [NUM_REQ-1:0] pending_r;
  logic [NUM_REQ-1:0] pending_nxt_s;
  logic               err_r;
  logic               err_nxt_s;
  logic               tmo_s;
  logic               abort_s;
  logic               cmd_valid_r;
  logic [CMD_W-1:0]   cmd_code_r;
  logic               pic_valid_r;
  logic [IDX_W-1:0]   pic_mode_r;
  logic               busy_r;
  logic               drop_r;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_sync
    edge_sync u_req_sync (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .din   (req_i[i]),
      .pulse (req_edge_s[i])
    );
  end

  edge_sync u_fin_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .din   (finish_i),
    .pulse (fin_edge_s)
  );

  // Lowest pending index wins: scanning downward lets lower indices overwrite higher ones.
  always_comb begin
    sel_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sel_s = pending_r[i] ? IDX_W'(i) : sel_s;
    end
  end

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_r;
  logic            timed_s;

  assign timed_s = (state_r == ST_ANNOUNCE) || (state_r == ST_WORK) || (state_r == ST_RETURN);
  assign tmo_s   = timed_s && (cnt_r == TO_LAST);

  // Watchdog counter restarts on every state change and idles outside the handshake states.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!timed_s || (state_nxt_s != state_r)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + TO_W'(1);
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // Next-state logic; a matching done always beats a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt_s   = state_r;
    grant_nxt_s   = grant_r;
    pending_nxt_s = pending_r;
    err_nxt_s     = err_r;
    abort_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r != '0) begin
          state_nxt_s   = ST_ANNOUNCE;
          grant_nxt_s   = sel_s;
          pending_nxt_s = '0;
          err_nxt_s     = 1'b0;
        end else begin
          pending_nxt_s = req_edge_s;
        end
      end
      ST_ANNOUNCE: begin
        if (bus.cmd_done) begin
          state_nxt_s = ST_WORK;
        end else if (tmo_s) begin
          state_nxt_s = ST_RETURN;
          err_nxt_s   = 1'b1;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_ANNOUNCE;
        end
      end
      ST_WORK: begin
        if (bus.pic_done) begin
          state_nxt_s = HOLD_MASK[grant_r] ? ST_HOLD : ST_RETURN;
        end else if (tmo_s) begin
          state_nxt_s = ST_RETURN;
          err_nxt_s   = 1'b1;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_WORK;
        end
      end
      ST_HOLD: begin
        if (fin_edge_s) begin
          state_nxt_s = ST_RETURN;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_RETURN: begin
        if (bus.cmd_done) begin
          state_nxt_s = ST_IDLE;
        end else if (tmo_s) begin
          state_nxt_s = ST_IDLE;
          err_nxt_s   = 1'b1;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_RETURN;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        pending_nxt_s = '0;
      end
    endcase
  end

  // State and registered outputs; an aborted handshake keeps cmd_valid low for one cycle so the valid visibly drops.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      grant_r     <= '0;
      pending_r   <= '0;
      err_r       <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_code_r  <= '0;
      pic_valid_r <= 1'b0;
      pic_mode_r  <= '0;
      busy_r      <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      pending_r   <= pending_nxt_s;
      err_r       <= err_nxt_s;
      cmd_valid_r <= ((state_nxt_s == ST_ANNOUNCE) || (state_nxt_s == ST_RETURN)) && !abort_s;
      cmd_code_r  <= (state_nxt_s == ST_ANNOUNCE) ? (CMD_W'(grant_nxt_s) + CMD_W'(1)) : CMD_W'(CMD_IDLE);
      pic_valid_r <= (state_nxt_s == ST_WORK);
      pic_mode_r  <= (state_nxt_s == ST_WORK) ? grant_nxt_s : '0;
      busy_r      <= (state_nxt_s != ST_IDLE);
      drop_r      <= (state_r != ST_IDLE) && (req_edge_s != '0);
    end
  end

  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_code  = cmd_code_r;
  assign bus.pic_valid = pic_valid_r;
  assign bus.pic_mode  = pic_mode_r;
  assign busy          = busy_r;
  assign req_drop      = drop_r;
  assign err           = err_r;
  assign status        = state_r;
endmodule

// File: tb/tb_mode_sequencer.sv
// Randomized self-checking bench for mode_sequencer; the timeout scenario is built when MODE_SEQ_TIMEOUT_EN is defined.
module tb_mode_sequencer;
  localparam int         NUM_REQ   = 3;
  localparam int         CMD_W     = 2;
  localparam int         IDX_W     = 2;
  localparam int         TMO       = 16;
  localparam logic [2:0] HOLD_MASK = 3'b100;

  logic       sys_clk  = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] req_i    = 3'b000;
  logic       finish_i = 1'b0;
  logic       busy;
  logic       req_drop;
  logic       err;
  logic [2:0] status;
  int         total    = 0;
  int         bad      = 0;
  int         drop_cnt = 0;

  mode_sequencer_if #(.CMD_W(CMD_W), .IDX_W(IDX_W)) bus ();

  mode_sequencer #(
    .NUM_REQ        (NUM_REQ),
    .CMD_W          (CMD_W),
    .HOLD_MASK      (HOLD_MASK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .finish_i (finish_i),
    .bus      (bus),
    .busy     (busy),
    .req_drop (req_drop),
    .err      (err),
    .status   (status)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (req_drop === 1'b1) drop_cnt <= drop_cnt + 1;
  end

  // Reference rules: lowest requested channel wins; channels in HOLD_MASK wait for finish.
  function automatic int model_grant(input logic [2:0] r);
    for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req_i = r;
    tick();
    req_i = 3'b000;
  endtask

  task automatic pulse_fin();
    finish_i = 1'b1;
    tick();
    finish_i = 1'b0;
  endtask

  task automatic serve_cmd(input int lat, output int code, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (bus.cmd_valid !== 1'b1 && n < 40) begin tick(); n++; end
    if (bus.cmd_valid !== 1'b1) begin ok = 1'b0; code = -1; return; end
    code = int'(bus.cmd_code);
    for (int k = 0; k < lat; k++) begin
      tick();
      if (bus.cmd_valid !== 1'b1 || int'(bus.cmd_code) != code || bus.pic_valid !== 1'b0) ok = 1'b0;
    end
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    if (bus.cmd_valid !== 1'b0) ok = 1'b0;
  endtask

  task automatic serve_pic(input int lat, input int fin_at, input logic [2:0] inj, output int mode, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (bus.pic_valid !== 1'b1 && n < 40) begin tick(); n++; end
    if (bus.pic_valid !== 1'b1) begin ok = 1'b0; mode = -1; return; end
    mode = int'(bus.pic_mode);
    for (int k = 0; k < lat; k++) begin
      if (k == 0) req_i = req_i | inj;
      if (k == 1) req_i = req_i & ~inj;
      finish_i = (k == fin_at);
      tick();
      if (bus.pic_valid !== 1'b1 || int'(bus.pic_mode) != mode || bus.cmd_valid !== 1'b0) ok = 1'b0;
    end
    req_i    = req_i & ~inj;
    finish_i = 1'b0;
    bus.pic_done = 1'b1;
    tick();
    bus.pic_done = 1'b0;
    if (bus.pic_valid !== 1'b0) ok = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] r, input int cl, input int pl, input logic [2:0] inj,
                         output int c1, output int m, output int c0, output bit held, output bit ok);
    bit ok1, ok2, ok3;
    pulse_req(r);
    serve_cmd(cl, c1, ok1);
    serve_pic(pl, -1, inj, m, ok2);
    held = (status === 3'd3);
    if (held) begin
      repeat (3) tick();
      held = (status === 3'd3) && (bus.cmd_valid === 1'b0);
      pulse_fin();
    end
    serve_cmd(cl, c0, ok3);
    ok = ok1 && ok2 && ok3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if ({bus.cmd_valid, bus.pic_valid, busy, req_drop, err} !== 5'b00000) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {bus.cmd_valid, bus.pic_valid, busy, req_drop, err}); end
    total++; if (status !== 3'd0 || bus.cmd_code !== 2'd0 || bus.pic_mode !== 2'd0) begin
      bad++; $display("FAIL reset_payload status=%0d code=%0d mode=%0d want all 0", status, bus.cmd_code, bus.pic_mode); end
    rst_n = 1'b1;
    repeat (3) tick();
    total++; if (status !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle status=%0d busy=%b want 0/0", status, busy); end
  endtask

  task automatic test_basic();
    int c1, m, c0; bit held, ok;
    run_txn(3'b010, 5, 10, 3'b000, c1, m, c0, held, ok);
    total++; if (c1 != 2) begin bad++; $display("FAIL basic_code got=%0d want=2", c1); end
    total++; if (m != 1) begin bad++; $display("FAIL basic_mode got=%0d want=1", m); end
    total++; if (c0 != 0 || held) begin bad++; $display("FAIL basic_return code=%0d held=%b want 0/0", c0, held); end
    total++; if (!ok) begin bad++; $display("FAIL basic_handshake got=%b want=1", ok); end
    tick();
    total++; if (status !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle status=%0d busy=%b want 0/0", status, busy); end
  endtask

  task automatic test_priority();
    int c1, m, c0; bit held, ok, extra;
    run_txn(3'b111, 2, 3, 3'b000, c1, m, c0, held, ok);
    total++; if (c1 != 1 || m != 0) begin bad++; $display("FAIL prio_grant code=%0d mode=%0d want 1/0", c1, m); end
    total++; if (c0 != 0 || !ok) begin bad++; $display("FAIL prio_return code=%0d ok=%b want 0/1", c0, ok); end
    extra = 1'b0;
    repeat (12) begin tick(); if (bus.cmd_valid !== 1'b0 || status !== 3'd0) extra = 1'b1; end
    total++; if (extra) begin bad++; $display("FAIL prio_no_regrant got=1 want=0"); end
  endtask

  task automatic test_hold();
    int c, m; bit ok1, ok2, ok3, stay;
    pulse_req(3'b100);
    serve_cmd(2, c, ok1);
    total++; if (c != 3) begin bad++; $display("FAIL hold_code got=%0d want=3", c); end
    serve_pic(10, 2, 3'b000, m, ok2);
    total++; if (m != 2 || status !== 3'd3) begin bad++; $display("FAIL hold_enter mode=%0d status=%0d want 2/3", m, status); end
    bus.cmd_done = 1'b1; tick(); bus.cmd_done = 1'b0;
    bus.pic_done = 1'b1; tick(); bus.pic_done = 1'b0;
    tick();
    total++; if (status !== 3'd3 || bus.cmd_valid !== 1'b0) begin
      bad++; $display("FAIL hold_stays status=%0d cmd_valid=%b want 3/0", status, bus.cmd_valid); end
    pulse_fin();
    repeat (2) tick();
    stay = (bus.cmd_valid === 1'b0);
    tick();
    total++; if (!stay || bus.cmd_valid !== 1'b1 || status !== 3'd4) begin
      bad++; $display("FAIL hold_finish_latency early_ok=%b cmd_valid=%b status=%0d want 1/1/4", stay, bus.cmd_valid, status); end
    serve_cmd(1, c, ok3);
    total++; if (c != 0 || !(ok1 && ok2 && ok3)) begin
      bad++; $display("FAIL hold_return code=%0d ok=%b want 0/1", c, ok1 && ok2 && ok3); end
  endtask

  task automatic test_level_latency();
    int c, m, d0; bit ok1, ok2, ok3, early, extra;
    d0 = drop_cnt;
    req_i = 3'b001;
    tick();
    repeat (3) tick();
    early = (bus.cmd_valid === 1'b0);
    tick();
    total++; if (!early || bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'd1) begin
      bad++; $display("FAIL latency early_ok=%b cmd_valid=%b code=%0d want 1/1/1", early, bus.cmd_valid, bus.cmd_code); end
    serve_cmd(1, c, ok1);
    serve_pic(3, -1, 3'b000, m, ok2);
    serve_cmd(2, c, ok3);
    extra = 1'b0;
    repeat (10) begin tick(); if (bus.cmd_valid !== 1'b0) extra = 1'b1; end
    req_i = 3'b000;
    repeat (5) begin tick(); if (bus.cmd_valid !== 1'b0) extra = 1'b1; end
    total++; if (extra || !(ok1 && ok2 && ok3)) begin
      bad++; $display("FAIL level_single extra=%b ok=%b want 0/1", extra, ok1 && ok2 && ok3); end
    total++; if (drop_cnt != d0) begin bad++; $display("FAIL level_drop got=%0d want=%0d", drop_cnt, d0); end
  endtask

  task automatic test_drop();
    int c1, m, c0, d0; bit held, ok, extra;
    d0 = drop_cnt;
    run_txn(3'b010, 2, 6, 3'b001, c1, m, c0, held, ok);
    repeat (2) tick();
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL drop_pulse got=%0d want=1", drop_cnt - d0); end
    extra = 1'b0;
    repeat (10) begin tick(); if (bus.cmd_valid !== 1'b0) extra = 1'b1; end
    total++; if (extra || c1 != 2 || !ok) begin
      bad++; $display("FAIL drop_no_grant extra=%b code=%0d ok=%b want 0/2/1", extra, c1, ok); end
  endtask

  task automatic test_random();
    int c1, m, c0, g, cl, pl, d0; bit held, ok; logic [2:0] r, inj;
    for (int it = 0; it < 10; it++) begin
      r   = 3'($urandom_range(1, 7));
      cl  = $urandom_range(1, 6);
      pl  = $urandom_range(1, 8);
      inj = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      d0  = drop_cnt;
      run_txn(r, cl, pl, inj, c1, m, c0, held, ok);
      g = model_grant(r);
      total++; if (c1 != g + 1) begin bad++; $display("FAIL rnd_code req=%b got=%0d want=%0d", r, c1, g + 1); end
      total++; if (m != g) begin bad++; $display("FAIL rnd_mode req=%b got=%0d want=%0d", r, m, g); end
      total++; if (held != HOLD_MASK[g]) begin bad++; $display("FAIL rnd_hold req=%b got=%b want=%b", r, held, HOLD_MASK[g]); end
      total++; if (c0 != 0 || !ok) begin bad++; $display("FAIL rnd_return code=%0d ok=%b want 0/1", c0, ok); end
      repeat (3) tick();
      total++; if (drop_cnt - d0 != ((inj != 3'b000) ? 1 : 0)) begin
        bad++; $display("FAIL rnd_drop inj=%b got=%0d want=%0d", inj, drop_cnt - d0, (inj != 3'b000) ? 1 : 0); end
      total++; if (status !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
        bad++; $display("FAIL rnd_idle status=%0d busy=%b err=%b want 0/0/0", status, busy, err); end
    end
  endtask

`ifdef MODE_SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    int c, m, n; bit ok1, ok2, ok3, pre;
    pulse_req(3'b010);
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (bus.cmd_valid !== 1'b1) begin bad++; $display("FAIL wd_announce got=%b want=1", bus.cmd_valid); end
    repeat (TMO - 1) tick();
    pre = (err === 1'b0) && (bus.cmd_valid === 1'b1);
    tick();
    total++; if (!pre || err !== 1'b1 || bus.cmd_valid !== 1'b0 || status !== 3'd4) begin
      bad++; $display("FAIL wd_expire pre_ok=%b err=%b cmd_valid=%b status=%0d want 1/1/0/4", pre, err, bus.cmd_valid, status); end
    serve_cmd(1, c, ok1);
    tick();
    total++; if (c != 0 || status !== 3'd0 || err !== 1'b1) begin
      bad++; $display("FAIL wd_return code=%0d status=%0d err=%b want 0/0/1", c, status, err); end
    pulse_req(3'b001);
    serve_cmd(1, c, ok1);
    total++; if (err !== 1'b0 || c != 1) begin bad++; $display("FAIL wd_err_clear err=%b code=%0d want 0/1", err, c); end
    serve_pic(2, -1, 3'b000, m, ok2);
    serve_cmd(1, c, ok3);
    total++; if (!(ok1 && ok2 && ok3) || c != 0) begin bad++; $display("FAIL wd_recover ok=%b code=%0d want 1/0", ok1 && ok2 && ok3, c); end
  endtask
`else
  task automatic test_watchdog();
    int c, m; bit ok1, ok2, ok3;
    pulse_req(3'b010);
    repeat (40) tick();
    total++; if (bus.cmd_valid !== 1'b1 || status !== 3'd1 || err !== 1'b0) begin
      bad++; $display("FAIL no_wd_wait cmd_valid=%b status=%0d err=%b want 1/1/0", bus.cmd_valid, status, err); end
    serve_cmd(1, c, ok1);
    serve_pic(2, -1, 3'b000, m, ok2);
    serve_cmd(1, c, ok3);
    total++; if (!(ok1 && ok2 && ok3) || c != 0 || m != 1 || err !== 1'b0) begin
      bad++; $display("FAIL no_wd_finish ok=%b code=%0d mode=%0d err=%b want 1/0/1/0", ok1 && ok2 && ok3, c, m, err); end
  endtask
`endif

  task automatic test_reset_mid();
    int c; bit ok, bad_seen;
    pulse_req(3'b001);
    serve_cmd(2, c, ok);
    repeat (2) tick();
    total++; if (bus.pic_valid !== 1'b1 || status !== 3'd2) begin
      bad++; $display("FAIL rst_mid_work pic_valid=%b status=%0d want 1/2", bus.pic_valid, status); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.cmd_valid, bus.pic_valid, busy, req_drop, err, status, bus.pic_mode, bus.cmd_code} !== 12'd0) begin
      bad++; $display("FAIL rst_mid_async got=%b want=0", {bus.cmd_valid, bus.pic_valid, busy, req_drop, err, status, bus.pic_mode, bus.cmd_code}); end
    tick();
    rst_n = 1'b1;
    bad_seen = 1'b0;
    repeat (10) begin tick(); if (bus.cmd_valid !== 1'b0 || status !== 3'd0) bad_seen = 1'b1; end
    total++; if (bad_seen) begin bad++; $display("FAIL rst_mid_no_announce got=1 want=0"); end
  endtask

  initial begin
    bus.cmd_done = 1'b0;
    bus.pic_done = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_hold();
    test_level_latency();
    test_drop();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
